// File: rtl/tc_pkg.sv
// -----------------------------------------------------------------------------
// tc_pkg
// Shared definitions for the traffic-controller slice:
//   - deb_state_t   : loop-detector debounce state encoding
//   - DEB_CYC_DEF   : default debounce length (also used by timer settings)
//   - DRAIN_CYC_DEF : default green cycles needed to discharge one vehicle
//   - is_occupied() : true while the debouncer considers the loop occupied
// -----------------------------------------------------------------------------
package tc_pkg;

  localparam int DEB_CYC_DEF   = 4;
  localparam int DRAIN_CYC_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    OCC      = 2'd2,
    FALL_CHK = 2'd3
  } deb_state_t;

  // A vehicle is still on the loop until the falling edge has been confirmed,
  // so FALL_CHK counts as occupied.
  function automatic logic is_occupied(input deb_state_t s);
    return (s == OCC) || (s == FALL_CHK);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for raw inputs asynchronous to clk.
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous, active-low reset (flops clear to 0)
//   d      in  W  asynchronous input
//   q      out W  synchronised output, two cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/fw_sensor_cond.sv
// -----------------------------------------------------------------------------
// fw_sensor_cond
// Turns the raw farm-way loop detector into the car_on_fw request for the
// hw/fw light controllers: synchronise, debounce, count arrivals, drain the
// count while farm-way is green, and hold the request while vehicles wait.
//
// Optional build macro: STUCK_DETECT_EN
//   defined   -> occupancy counter; STUCK_CYC continuous occupied cycles set a
//                sticky sensor_fault and force car_on_fw high (fail-safe).
//   undefined -> no occupancy counter, sensor_fault tied 0.
//
// Ports:
//   clk          in  1      system clock, rising edge
//   reset        in  1      asynchronous, active-low reset
//   loop_raw     in  1      raw loop detector, asynchronous to clk
//   fw_green     in  1      farm-way green indication
//   car_on_fw    out 1      vehicle(s) waiting on farm-way (registered)
//   arrival      out 1      one-cycle pulse per accepted arrival
//   wait_cnt     out CNT_W  vehicles currently waiting
//   sensor_fault out 1      stuck-loop fault
// -----------------------------------------------------------------------------
module fw_sensor_cond
  import tc_pkg::*;
#(
  parameter int DEB_CYC   = DEB_CYC_DEF,
  parameter int CNT_W     = 4,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
`ifdef STUCK_DETECT_EN
  ,
  parameter int STUCK_CYC = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loop_raw,
  input  logic             fw_green,
  output logic             car_on_fw,
  output logic             arrival,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             sensor_fault
);

  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  logic loop_s;

  sync_2ff #(.W(1)) u_sync_loop (
    .clk   (clk),
    .reset (reset),
    .d     (loop_raw),
    .q     (loop_s)
  );

  deb_state_t         state_reg, state_next;
  logic [DEB_W-1:0]   deb_cnt_reg, deb_cnt_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic               car_reg, car_next;
  logic               arrival_c;
  logic               drain_dec;
  logic               fault_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      deb_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      car_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      deb_cnt_reg   <= deb_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      car_reg       <= car_next;
    end
  end

  // Debounce: the same counter times both the rising and falling checks; it
  // is cleared on entry to each check state.
  always_comb begin
    state_next   = state_reg;
    deb_cnt_next = deb_cnt_reg;
    arrival_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (loop_s) begin
          state_next   = RISE_CHK;
          deb_cnt_next = '0;
        end
      end
      RISE_CHK: begin
        if (!loop_s) begin
          state_next = IDLE;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next = OCC;
          arrival_c  = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
      end
      OCC: begin
        if (!loop_s) begin
          state_next   = FALL_CHK;
          deb_cnt_next = '0;
        end
      end
      FALL_CHK: begin
        // Loop re-asserting here is the same vehicle, not a new arrival.
        if (loop_s) begin
          state_next = OCC;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next = IDLE;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drain: only advances while something is waiting, so a vehicle arriving
  // during green always needs a full DRAIN_CYC window to be discharged.
  always_comb begin
    drain_cnt_next = '0;
    drain_dec      = 1'b0;
    if (fw_green && (wait_cnt_reg != '0)) begin
      if (drain_cnt_reg == DRAIN_LAST) begin
        drain_dec = 1'b1;
      end else begin
        drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
      end
    end
  end

  // Waiting count: arrival and discharge in the same cycle cancel out.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (arrival_c && !drain_dec) begin
      if (wait_cnt_reg != CNT_MAX) begin
        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
      end
    end else if (!arrival_c && drain_dec) begin
      wait_cnt_next = wait_cnt_reg - CNT_W'(1);
    end
  end

  always_comb begin
    car_next = (wait_cnt_reg != '0) | is_occupied(state_reg) | fault_w;
  end

`ifdef STUCK_DETECT_EN
  localparam int OCC_W = $clog2(STUCK_CYC + 1);
  localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(STUCK_CYC - 1);

  logic [OCC_W-1:0] occ_cnt_reg;
  logic             fault_reg;

  // Counts consecutive occupied cycles; the counter parks at its last value
  // once the fault is latched, and the fault itself clears only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_cnt_reg <= '0;
      fault_reg   <= 1'b0;
    end else if (!is_occupied(state_reg)) begin
      occ_cnt_reg <= '0;
    end else if (occ_cnt_reg == OCC_LAST) begin
      fault_reg   <= 1'b1;
    end else begin
      occ_cnt_reg <= occ_cnt_reg + OCC_W'(1);
    end
  end

  assign fault_w = fault_reg;
`else
  assign fault_w = 1'b0;
`endif

  assign car_on_fw    = car_reg;
  assign arrival      = arrival_c;
  assign wait_cnt     = wait_cnt_reg;
  assign sensor_fault = fault_w;

endmodule
